// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- round-robin arbiter for the single Common Data Bus.
//
// The result producers (0 = alu, 1 = mul, 2 = branch, 3 = ldst) present
// finished results. Each cycle at most one of them is granted. The winning
// record is registered into a one-cycle broadcast stage that the ROB and all
// reservation stations / LSQ snoop.
//
// Ports:
//   clk          single clock
//   rst          asynchronous, active-high reset
//   flush        mispredict recovery: no grant this cycle, no broadcast next
//   req_valid    [N_REQ]        requester i holds a result
//   req_cdb      [N_REQ] cdb_t  per-requester result record
//   req_ready    [N_REQ]        one-hot-or-zero grant (combinational)
//   cdb_valid    broadcast stage holds a valid result (one cycle per result)
//   cdb          broadcast record (holds its value while cdb_valid = 0)
//   cdb_src      index of the requester behind the current broadcast
//   bcast_count  broadcasts since reset, wraps

package cdb_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_W     = $clog2(ROB_DEPTH);

  // 203-bit result record carried on the CDB.
  typedef struct packed {
    logic [ROB_W-1:0] rob_entry;
    logic [63:0]      rd_data;
    logic [63:0]      pc;
    logic [63:0]      target;
    logic             exception;
    logic [4:0]       exc_cause;
    logic             mispredict;
    logic             taken;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ = 4  // must be >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  input  cdb_t [N_REQ-1:0]         req_cdb,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     cdb_valid,
  output cdb_t                     cdb,
  output logic [$clog2(N_REQ)-1:0] cdb_src,
  output logic [31:0]              bcast_count
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win;
  logic             found;
  logic             transfer;

  // (base + off) mod N_REQ without relying on power-of-two wrap, so the
  // result never indexes past N_REQ-1.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N_REQ)) s = s - 32'(N_REQ);
    return PTR_W'(s);
  endfunction

  // Search req_valid starting at rr_ptr; the first set bit wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so that no path
    // through this block leaves it unassigned, which would infer a latch.
    found     = 1'b0;
    win       = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[wrap_add(rr_ptr, k)]) begin
        found = 1'b1;
        win   = wrap_add(rr_ptr, k);
      end
    end
    // No grants during reset or flush, whatever is pending.
    if (found && !rst && !flush) req_ready[win] = 1'b1;
  end

  assign transfer = |(req_valid & req_ready);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb         <= '0;
      cdb_src     <= '0;
      bcast_count <= '0;
    end else begin
      // A broadcast lives for exactly one cycle; payload holds when idle.
      cdb_valid <= transfer;
      if (transfer) begin
        cdb         <= req_cdb[win];
        cdb_src     <= win;
        rr_ptr      <= wrap_add(win, 1);
        bcast_count <= bcast_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios followed by a randomized
// phase, all checked against a behavioural round-robin model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [N-1:0]     req_valid;
  cdb_t [N-1:0]     req_cdb;
  logic [N-1:0]     req_ready;
  logic             cdb_valid;
  cdb_t             cdb;
  logic [1:0]       cdb_src;
  logic [31:0]      bcast_count;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_ptr;
  logic        m_valid;
  cdb_t        m_cdb;
  logic [1:0]  m_src;
  logic [31:0] m_count;

  cdb_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_cdb    (req_cdb),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb        (cdb),
    .cdb_src    (cdb_src),
    .bcast_count(bcast_count)
  );

  always #5 clk = ~clk;

  function automatic cdb_t rand_cdb();
    logic [223:0] bits;
    bits = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return cdb_t'(bits[202:0]);
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_cdb   = '0;
    m_src   = '0;
    m_count = '0;
  endtask

  // One clock cycle. Inputs are already applied (just after a falling edge).
  // Checks the combinational grant, predicts the edge, then checks the
  // broadcast stage at the next falling edge. The granted requester drops.
  task automatic cycle(input string tag);
    int         w;
    logic [N-1:0] exp_ready;
    #1;
    w = -1;
    exp_ready = '0;
    if (!flush && !rst) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    if (w >= 0) exp_ready[w] = 1'b1;
    checks++;
    assert (req_ready === exp_ready) else begin
      errors++;
      $error("FAIL %s ready: got %b exp %b", tag, req_ready, exp_ready);
    end
    if (w >= 0) begin
      m_valid = 1'b1;
      m_cdb   = req_cdb[w];
      m_src   = 2'(w);
      m_ptr   = (w + 1) % N;
      m_count = m_count + 1;
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    assert (cdb_valid === m_valid) else begin
      errors++;
      $error("FAIL %s cdb_valid: got %b exp %b", tag, cdb_valid, m_valid);
    end
    checks++;
    assert (cdb_src === m_src) else begin
      errors++;
      $error("FAIL %s cdb_src: got %0d exp %0d", tag, cdb_src, m_src);
    end
    checks++;
    assert (cdb === m_cdb) else begin
      errors++;
      $error("FAIL %s cdb: got %h exp %h", tag, cdb, m_cdb);
    end
    checks++;
    assert (bcast_count === m_count) else begin
      errors++;
      $error("FAIL %s bcast_count: got %0d exp %0d", tag, bcast_count, m_count);
    end
    if (w >= 0) req_valid[w] = 1'b0;
  endtask

  initial begin
    model_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_cdb[i]           = rand_cdb();
      req_cdb[i].rob_entry = 3'(i);
    end

    // Reset: no grant even with all requests pending, registers cleared.
    #3;
    checks++;
    assert (req_ready === 4'b0000) else begin
      errors++; $error("FAIL rst_ready: got %b exp 0000", req_ready);
    end
    checks++;
    assert (cdb_valid === 1'b0) else begin
      errors++; $error("FAIL rst_cdb_valid: got %b exp 0", cdb_valid);
    end
    checks++;
    assert (cdb === cdb_t'(0)) else begin
      errors++; $error("FAIL rst_cdb: got %h exp 0", cdb);
    end
    @(negedge clk);
    rst = 1'b0;

    // Full contention: grants 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b1111;
      cycle("contend");
      checks++;
      assert (cdb.rob_entry === 3'(c % 4)) else begin
        errors++; $error("FAIL contend_order: got %0d exp %0d", cdb.rob_entry, c % 4);
      end
    end
    req_valid = 4'b0000;
    checks++;
    assert (bcast_count === 32'd8) else begin
      errors++; $error("FAIL contend_count: got %0d exp 8", bcast_count);
    end

    // Pointer wrap: req 3 alone, then 0 and 3 together -> 0 then 3.
    req_valid = 4'b1000;
    cycle("wrap3");
    req_valid = 4'b1001;
    cycle("wrap0");
    checks++;
    assert (cdb_src === 2'd0) else begin
      errors++; $error("FAIL wrap_src0: got %0d exp 0", cdb_src);
    end
    cycle("wrap3b");
    checks++;
    assert (cdb_src === 2'd3) else begin
      errors++; $error("FAIL wrap_src3: got %0d exp 3", cdb_src);
    end

    // Idle gap, then a single result from req 2; payload holds afterwards.
    for (int c = 0; c < 3; c++) cycle("idle");
    req_cdb[2]         = rand_cdb();
    req_cdb[2].rd_data = 64'hDEADBEEF;
    req_valid          = 4'b0100;
    cycle("single");
    checks++;
    assert (cdb_valid === 1'b1 && cdb.rd_data === 64'hDEADBEEF) else begin
      errors++; $error("FAIL single_pulse: got v=%b d=%h exp v=1 d=deadbeef", cdb_valid, cdb.rd_data);
    end
    for (int c = 0; c < 2; c++) cycle("after");
    checks++;
    assert (cdb_valid === 1'b0 && cdb.rd_data === 64'hDEADBEEF) else begin
      errors++; $error("FAIL hold_payload: got v=%b d=%h exp v=0 d=deadbeef", cdb_valid, cdb.rd_data);
    end

    // Flush with reqs 1 and 2 pending: nothing granted, then req 1 wins.
    req_valid = 4'b0110;
    flush     = 1'b1;
    cycle("flush");
    flush = 1'b0;
    cycle("post_flush");
    checks++;
    assert (cdb_src === 2'd1) else begin
      errors++; $error("FAIL flush_winner: got %0d exp 1", cdb_src);
    end
    cycle("post_flush2");

    // Randomized traffic with legal hold behaviour and occasional flush.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          req_valid[i] = 1'b1;
          req_cdb[i]   = rand_cdb();
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      cycle("random");
      if (flush) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0;
        flush = 1'b0;
      end
    end

    // Mid-operation reset while a broadcast is live.
    req_valid = 4'b1111;
    cycle("pre_reset");
    req_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    assert (cdb_valid === 1'b0 && cdb_src === 2'd0 && bcast_count === 32'd0) else begin
      errors++;
      $error("FAIL async_rst: got v=%b src=%0d cnt=%0d exp 0/0/0", cdb_valid, cdb_src, bcast_count);
    end
    checks++;
    assert (req_ready === 4'b0000) else begin
      errors++; $error("FAIL async_rst_ready: got %b exp 0000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    cycle("after_reset");
    checks++;
    assert (cdb_src === 2'd0 && cdb_valid === 1'b1) else begin
      errors++; $error("FAIL after_reset_src: got %0d v=%b exp 0 v=1", cdb_src, cdb_valid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) between the functional-unit result producers (alu, mul, branch, ldst). Each cycle it selects at most one pending result, acknowledges the producer, and drives the winning `cdb_t` record onto a registered broadcast stage. The ROB and all reservation stations / LSQ snoop that stage. A flush input discards in-flight broadcasts on mispredict recovery.

## Interface
- `N_REQ`, default 4: number of requesters. Index mapping: 0 = alu, 1 = mul, 2 = branch, 3 = ldst.
- `ROB_DEPTH`, default 8 (package value): sets the `rob_entry` width, `$clog2(ROB_DEPTH)` = 3.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline flush; kills the current grant and the next broadcast.
- `req_valid` in `N_REQ`: requester i holds a result.
- `req_cdb` in `N_REQ` x `cdb_t`: per-requester result record (203 bits each).
- `req_ready` out `N_REQ`: one-hot-or-zero grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `cdb_valid` out 1: broadcast stage holds a valid result.
- `cdb` out `cdb_t`: broadcast record.
- `cdb_src` out `$clog2(N_REQ)`: index of the requester that produced the current broadcast.
- `bcast_count` out 32: number of broadcasts since reset; wraps.

## Operation
- **Grant logic (combinational).**
  - Search `req_valid` starting at `rr_ptr` and wrapping modulo `N_REQ`.
  - The first set bit wins; `req_ready[win] = 1` and all other ready bits are 0.
  - When no request is pending, all `req_ready` bits are 0.
  - When `flush = 1`, all `req_ready` bits are 0 regardless of requests.
- **Round-robin pointer `rr_ptr`.**
  - On a transfer from winner w: `rr_ptr <= (w+1) mod N_REQ`.
  - With no transfer, it holds.
  - With `N_REQ` not a power of two, the wrap is explicit; it must never index past `N_REQ-1`.
- **Broadcast register.**
  - On a transfer: `cdb <= req_cdb[w]`, `cdb_src <= w`, `cdb_valid <= 1`.
  - With no transfer: `cdb_valid <= 0`, and `cdb`/`cdb_src` hold their old values. Consumers ignore them when `cdb_valid` is 0.
  - Each broadcast is valid for exactly one cycle. Consumers have no backpressure; the ROB and RS must capture on `cdb_valid`.
- **Flush.**
  - `flush = 1` at edge t gives `cdb_valid = 0` after edge t, whether or not a request was pending.
  - `rr_ptr` does not change on a flush cycle.
  - Requesters are responsible for dropping their own entries; the arbiter holds no storage beyond the broadcast register.
- **Requester rules.**
  - Once `req_valid[i]` rises, it and `req_cdb[i]` stay stable until the handshake completes.
  - The exception is a flush cycle, after which a requester may deassert.
  - The arbiter must not depend on `req_cdb` of non-winning requesters.
- **`bcast_count`.** Increments by 1 on every transfer and wraps from 0xFFFF_FFFF to 0.
- **Reset** (asynchronous, immediate, held while `rst = 1`): `cdb_valid = 0`, `cdb = 0`, `cdb_src = 0`, `rr_ptr = 0`, `bcast_count = 0`. `req_ready` is forced to 0 while in reset.

## Timing
- Request to grant: 0 cycles. `req_ready` is combinational from `req_valid`, `rr_ptr` and `flush`.
- Grant to broadcast: 1 cycle. A transfer at edge t gives `cdb_valid = 1` during cycle t+1.
- Throughput: one result per cycle. With all N requesters continuously valid, each is granted exactly once every N cycles.
- Worst-case wait for a held request: N−1 cycles (no starvation).
- Back-to-back broadcasts from different requesters are legal. The same requester may win consecutively only if it is the sole valid requester.
- Reset asserted mid-broadcast clears `cdb_valid` immediately and asynchronously. The first grant is possible on the first rising edge after deassertion.

## Test plan
- **Reset.** Assert `rst` with `req_valid = 4'b1111` → `req_ready = 0` and `cdb_valid = 0`. Release `rst` → first grant goes to req 0; next cycle `cdb_valid = 1`, `cdb_src = 0`.
- **Full contention.** Hold `req_valid = 4'b1111` for 8 cycles with distinct `rob_entry` 0..3 → grant order 0,1,2,3,0,1,2,3. `cdb.rob_entry` follows the same order one cycle later. `bcast_count = 8`.
- **Pointer wrap / fairness.**
  - Hold req 3 only → granted.
  - Then raise reqs 0 and 3 together → req 0 wins (`rr_ptr` wrapped to 0), then req 3.
- **Idle gap.** A single request at cycle 5 with `rd_data = 0xDEADBEEF` → `cdb_valid` pulses for exactly cycle 6 with `rd_data = 0xDEADBEEF`, then 0. `cdb` holds its value.
- **Flush.** Hold reqs 1 and 2 valid and assert `flush` for 1 cycle → no ready that cycle, `cdb_valid = 0` the next cycle, and `rr_ptr` is unchanged so req 1 wins after flush deasserts.
- **Mid-operation reset.** Assert `rst` asynchronously while `cdb_valid = 1` → `cdb_valid`, `bcast_count` and `cdb_src` are 0 before the next edge.
